// File: rtl/ps2_seq_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// ps2_seq_pkg : shared states, PS/2 byte constants and owner encoding
// Revision    : 1.0
// ============================================================================
package ps2_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE     = 3'd0;
  localparam state_t SEND     = 3'd1;
  localparam state_t WAIT_ACK = 3'd2;
  localparam state_t RETRY    = 3'd3;
  localparam state_t DONE     = 3'd4;
  localparam state_t ERR      = 3'd5;

  localparam logic [7:0] PS2_ACK          = 8'hFA;
  localparam logic [7:0] PS2_RESEND       = 8'hFE;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;

  localparam logic OWN_LED = 1'b0;
  localparam logic OWN_CMD = 1'b1;

  function automatic logic is_response(input logic [7:0] b);
    return (b == PS2_ACK) || (b == PS2_RESEND);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_req_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// ps2_req_arbiter : 2-way round-robin arbiter, grant only while sequencer idle
// Revision        : 1.0
// ============================================================================
module ps2_req_arbiter
  import ps2_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic idle,
  input  logic led_req,
  input  logic cmd_req,
  input  logic release_en,
  input  logic release_owner,
  output logic grant_valid,
  output logic grant_owner
);

  logic r_last_grant;

  // Owner history is committed when a transaction finishes, not at grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= OWN_CMD;
    end else if (release_en) begin
      r_last_grant <= release_owner;
    end
  end

  always_comb begin
    grant_valid = idle & (led_req | cmd_req);
    if (led_req && cmd_req) begin
      grant_owner = ~r_last_grant;
    end else if (cmd_req) begin
      grant_owner = OWN_CMD;
    end else begin
      grant_owner = OWN_LED;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_command_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// ps2_command_sequencer : arbitrates LED/command requests and sequences bytes
//                         to the PS/2 controller with ACK/resend/timeout retry
// Revision              : 1.0
// ============================================================================
module ps2_command_sequencer
  import ps2_seq_pkg::*;
#(
  parameter int ACK_TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRY          = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       led_req,
  input  logic [2:0] led_state,
  output logic       led_done,
  output logic       led_err,
  input  logic       cmd_req,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_has_arg,
  input  logic [7:0] cmd_arg,
  output logic       cmd_done,
  output logic       cmd_err,
  output logic       busy,
  output logic [7:0] the_command,
  output logic       send_command,
  input  logic       command_was_sent,
  input  logic       error_communication_timed_out,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic [7:0] scan_data,
  output logic       scan_valid
);

  localparam int                 RETRY_W     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [23:0]        TIMER_LAST  = 24'(ACK_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  state_t               r_state;
  logic                 r_owner;
  logic [7:0]           r_byte1;
  logic                 r_two_bytes;
  logic                 r_idx;
  logic [RETRY_W-1:0]   r_retry;
  logic [23:0]          r_timer;
  logic                 r_send;
  logic [7:0]           r_cmd;
  logic                 r_scan_valid;
  logic [7:0]           r_scan_data;

  logic w_idle;
  logic w_release;
  logic w_grant_valid;
  logic w_grant_owner;
  logic w_ack;
  logic w_resend;

  assign w_idle    = (r_state == IDLE);
  assign w_release = (r_state == DONE) || (r_state == ERR);
  assign w_ack     = received_data_en && (received_data == PS2_ACK);
  assign w_resend  = received_data_en && (received_data == PS2_RESEND);

  ps2_req_arbiter u_arbiter (
    .clk           (CLOCK_50),
    .rst_n         (reset_n),
    .idle          (w_idle),
    .led_req       (led_req),
    .cmd_req       (cmd_req),
    .release_en    (w_release),
    .release_owner (r_owner),
    .grant_valid   (w_grant_valid),
    .grant_owner   (w_grant_owner)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_owner     <= OWN_LED;
      r_byte1     <= 8'h00;
      r_two_bytes <= 1'b0;
      r_idx       <= 1'b0;
      r_retry     <= '0;
      r_timer     <= 24'd0;
      r_send      <= 1'b0;
      r_cmd       <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_owner <= w_grant_owner;
            r_idx   <= 1'b0;
            r_retry <= '0;
            r_send  <= 1'b1;
            r_state <= SEND;
            if (w_grant_owner == OWN_LED) begin
              r_cmd       <= PS2_CMD_SET_LEDS;
              r_byte1     <= {5'b00000, led_state};
              r_two_bytes <= 1'b1;
            end else begin
              r_cmd       <= cmd_byte;
              r_byte1     <= cmd_arg;
              r_two_bytes <= cmd_has_arg;
            end
          end
        end
        SEND: begin
          if (command_was_sent) begin
            r_send  <= 1'b0;
            r_timer <= 24'd0;
            r_state <= WAIT_ACK;
          end else if (error_communication_timed_out) begin
            r_send  <= 1'b0;
            r_state <= RETRY;
          end
        end
        WAIT_ACK: begin
          r_timer <= r_timer + 24'd1;
          // An ACK landing on the expiry cycle still counts as success.
          if (w_ack) begin
            if (r_two_bytes && !r_idx) begin
              r_idx   <= 1'b1;
              r_retry <= '0;
              r_cmd   <= r_byte1;
              r_send  <= 1'b1;
              r_state <= SEND;
            end else begin
              r_state <= DONE;
            end
          end else if (w_resend || (r_timer == TIMER_LAST)) begin
            r_state <= RETRY;
          end
        end
        RETRY: begin
          if (r_retry < RETRY_LIMIT) begin
            r_retry <= r_retry + RETRY_W'(1);
            r_send  <= 1'b1;
            r_state <= SEND;
          end else begin
            r_state <= ERR;
          end
        end
        DONE:    r_state <= IDLE;
        ERR:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // ACK/RESEND bytes are only swallowed while a response is expected.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_scan_valid <= 1'b0;
      r_scan_data  <= 8'h00;
    end else begin
      r_scan_valid <= 1'b0;
      if (received_data_en && !((r_state == WAIT_ACK) && is_response(received_data))) begin
        r_scan_valid <= 1'b1;
        r_scan_data  <= received_data;
      end
    end
  end

  assign busy         = ~w_idle;
  assign send_command = r_send;
  assign the_command  = r_cmd;
  assign led_done     = (r_state == DONE) && (r_owner == OWN_LED);
  assign cmd_done     = (r_state == DONE) && (r_owner == OWN_CMD);
  assign led_err      = (r_state == ERR)  && (r_owner == OWN_LED);
  assign cmd_err      = (r_state == ERR)  && (r_owner == OWN_CMD);
  assign scan_valid   = r_scan_valid;
  assign scan_data    = r_scan_data;

endmodule
`default_nettype wire

// File: tb/tb_ps2_command_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_ps2_command_sequencer : directed self-checking bench, Ps2Controller model
// Revision                 : 1.0
// ============================================================================
module tb_ps2_command_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       led_req, cmd_req, cmd_has_arg;
  logic [2:0] led_state;
  logic [7:0] cmd_byte, cmd_arg, received_data;
  logic       command_was_sent, error_communication_timed_out, received_data_en;
  logic       led_done, led_err, cmd_done, cmd_err, busy, send_command, scan_valid;
  logic [7:0] the_command, scan_data;

  int vectors = 0;
  int miscompares = 0;
  int n_led_done = 0, n_led_err = 0, n_cmd_done = 0, n_cmd_err = 0;
  int n_scan = 0, n_send_rise = 0;
  logic prev_send = 1'b0;

  always #10 clk = ~clk;

  ps2_command_sequencer #(.ACK_TIMEOUT_CYCLES(100), .MAX_RETRY(3)) dut (
    .CLOCK_50                      (clk),
    .reset_n                       (reset_n),
    .led_req                       (led_req),
    .led_state                     (led_state),
    .led_done                      (led_done),
    .led_err                       (led_err),
    .cmd_req                       (cmd_req),
    .cmd_byte                      (cmd_byte),
    .cmd_has_arg                   (cmd_has_arg),
    .cmd_arg                       (cmd_arg),
    .cmd_done                      (cmd_done),
    .cmd_err                       (cmd_err),
    .busy                          (busy),
    .the_command                   (the_command),
    .send_command                  (send_command),
    .command_was_sent              (command_was_sent),
    .error_communication_timed_out (error_communication_timed_out),
    .received_data                 (received_data),
    .received_data_en              (received_data_en),
    .scan_data                     (scan_data),
    .scan_valid                    (scan_valid)
  );

  always @(posedge clk) begin
    if (led_done)   n_led_done  <= n_led_done + 1;
    if (led_err)    n_led_err   <= n_led_err + 1;
    if (cmd_done)   n_cmd_done  <= n_cmd_done + 1;
    if (cmd_err)    n_cmd_err   <= n_cmd_err + 1;
    if (scan_valid) n_scan      <= n_scan + 1;
    if (send_command && !prev_send) n_send_rise <= n_send_rise + 1;
    prev_send <= send_command;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_send(input string tag, input int limit, output int cyc);
    cyc = 0;
    while (send_command !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, send_command, 1);
  endtask

  task automatic accept();
    command_was_sent = 1'b1;
    @(negedge clk);
    command_was_sent = 1'b0;
  endtask

  task automatic reply(input logic [7:0] b);
    received_data    = b;
    received_data_en = 1'b1;
    @(negedge clk);
    received_data_en = 1'b0;
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    int b_done, b_err, b_rise, b_scan;

    reset_n = 1'b0; led_req = 1'b0; cmd_req = 1'b0; cmd_has_arg = 1'b0;
    led_state = 3'b000; cmd_byte = 8'h00; cmd_arg = 8'h00; received_data = 8'h00;
    command_was_sent = 1'b0; error_communication_timed_out = 1'b0; received_data_en = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_send", send_command, 0);
    check("rst_cmd", the_command, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {led_done, led_err, cmd_done, cmd_err}, 0);
    check("rst_scan", {scan_valid, scan_data}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // LED update 3'b101: ED then 05, ACKs never forwarded
    b_scan = n_scan; b_done = n_led_done;
    led_state = 3'b101; led_req = 1'b1;
    @(negedge clk);
    check("t1_latency", send_command, 1);
    check("t1_busy", busy, 1);
    check("t1_byte0", the_command, 8'hED);
    led_req = 1'b0;
    accept();
    check("t1_send_drop", send_command, 0);
    reply(8'hFA);
    check("t1_byte1_send", send_command, 1);
    check("t1_byte1", the_command, 8'h05);
    check("t1_ack_not_fwd", scan_valid, 0);
    accept();
    reply(8'hFA);
    check("t1_led_done", led_done, 1);
    check("t1_cmd_done_quiet", cmd_done, 0);
    @(negedge clk);
    check("t1_done_1cyc", led_done, 0);
    check("t1_busy_low", busy, 0);
    @(negedge clk);
    check("t1_done_count", n_led_done - b_done, 1);
    check("t1_scan_count", n_scan - b_scan, 0);

    // single-byte command F4
    b_rise = n_send_rise;
    cmd_byte = 8'hF4; cmd_has_arg = 1'b0; cmd_arg = 8'h55; cmd_req = 1'b1;
    wait_send("t2_send", 10, cyc);
    check("t2_byte", the_command, 8'hF4);
    cmd_req = 1'b0;
    accept();
    reply(8'hFA);
    check("t2_cmd_done", cmd_done, 1);
    check("t2_busy_at_done", busy, 1);
    @(negedge clk);
    check("t2_busy_after", busy, 0);
    repeat (3) @(negedge clk);
    check("t2_one_send", n_send_rise - b_rise, 1);

    // both requests held from reset: LED, CMD, LED, CMD
    reset_n = 1'b0;
    led_state = 3'b010; cmd_byte = 8'hF4; cmd_has_arg = 1'b0;
    led_req = 1'b1; cmd_req = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_send("t3_send", 10, cyc);
      check("t3_order", the_command, (i % 2 == 0) ? 8'hED : 8'hF4);
      if (i == 3) begin
        led_req = 1'b0; cmd_req = 1'b0;
      end
      accept();
      reply(8'hFA);
      if (i % 2 == 0) begin
        wait_send("t3_led_b1_send", 10, cyc);
        check("t3_led_b1", the_command, 8'h02);
        accept();
        reply(8'hFA);
        check("t3_led_done", led_done, 1);
      end else begin
        check("t3_cmd_done", cmd_done, 1);
      end
    end
    repeat (2) @(negedge clk);

    // three RESENDs on ED, then ACK
    b_done = n_led_done;
    led_state = 3'b011; led_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_send("t4_send", 10, cyc);
      check("t4_byte0", the_command, 8'hED);
      led_req = 1'b0;
      accept();
      reply((i < 3) ? 8'hFE : 8'hFA);
      if (i < 3) begin
        check("t4_gap", send_command, 0);
        check("t4_fe_not_fwd", scan_valid, 0);
      end
    end
    wait_send("t4_b1_send", 10, cyc);
    check("t4_byte1", the_command, 8'h03);
    accept();
    reply(8'hFA);
    check("t4_led_done", led_done, 1);
    repeat (2) @(negedge clk);
    check("t4_done_count", n_led_done - b_done, 1);

    // no ACK ever: 4 attempts 101 cycles apart, then cmd_err
    b_rise = n_send_rise; b_err = n_cmd_err; b_done = n_cmd_done;
    cmd_byte = 8'hF3; cmd_has_arg = 1'b1; cmd_arg = 8'h14; cmd_req = 1'b1;
    wait_send("t5_send", 10, cyc);
    cmd_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t5_byte", the_command, 8'hF3);
      accept();
      if (i < 3) begin
        wait_send("t5_retry_send", 200, cyc);
        check("t5_spacing", cyc, 101);
      end
    end
    cyc = 0;
    while (cmd_err !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("t5_cmd_err", cmd_err, 1);
    check("t5_err_delay", cyc, 101);
    @(negedge clk);
    check("t5_err_1cyc", cmd_err, 0);
    check("t5_busy_low", busy, 0);
    repeat (3) @(negedge clk);
    check("t5_attempts", n_send_rise - b_rise, 4);
    check("t5_err_count", n_cmd_err - b_err, 1);
    check("t5_no_done", n_cmd_done - b_done, 0);

    // ACK on the exact timeout cycle wins
    b_rise = n_send_rise;
    cmd_byte = 8'hF4; cmd_has_arg = 1'b0; cmd_req = 1'b1;
    wait_send("t6_send", 10, cyc);
    cmd_req = 1'b0;
    accept();
    repeat (99) @(negedge clk);
    reply(8'hFA);
    check("t6_ack_wins", cmd_done, 1);
    repeat (3) @(negedge clk);
    check("t6_one_send", n_send_rise - b_rise, 1);

    // scan byte during WAIT_ACK, then forwarding of FA while idle
    cmd_req = 1'b1;
    wait_send("t7_send", 10, cyc);
    cmd_req = 1'b0;
    accept();
    reply(8'h1C);
    check("t7_scan_valid", scan_valid, 1);
    check("t7_scan_data", scan_data, 8'h1C);
    check("t7_still_busy", busy, 1);
    reply(8'hFA);
    check("t7_cmd_done", cmd_done, 1);
    check("t7_ack_not_fwd", scan_valid, 0);
    @(negedge clk);
    reply(8'hFA);
    check("t7_idle_fwd_valid", scan_valid, 1);
    check("t7_idle_fwd_data", scan_data, 8'hFA);

    // reset while in SEND
    b_done = n_led_done + n_cmd_done; b_err = n_led_err + n_cmd_err;
    led_state = 3'b001; led_req = 1'b1;
    wait_send("t8_send", 10, cyc);
    led_req = 1'b0;
    reset_n = 1'b0;
    #1;
    check("t8_async_send", send_command, 0);
    check("t8_async_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t8_no_done", n_led_done + n_cmd_done - b_done, 0);
    check("t8_no_err", n_led_err + n_cmd_err - b_err, 0);
    check("t8_send_stays_low", send_command, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_command_sequencer.md
Name: ps2_command_sequencer

Overview:
- Sits between host-side requesters and the Ps2Controller command interface.
- Arbitrates two requesters: keyboard LED updates, and generic 1- or 2-byte device commands.
- Sequences each transaction byte-by-byte: drives send_command, waits for device ACK 0xFA, and retries on 0xFE, transmit timeout or ACK timeout.
- Forwards all non-response received bytes to the scan-code consumer.

Parameters:
ACK_TIMEOUT_CYCLES, 1000000, CLOCK_50 cycles to wait for ACK after command_was_sent (20 ms); must be < 2^24
MAX_RETRY, 3, resends allowed per byte before abort (MAX_RETRY+1 attempts total)

Ports:
CLOCK_50  in  1  system clock
reset_n  in  1  asynchronous active-low reset
led_req  in  1  level; request LED update
led_state  in  3  {caps, num, scroll}; sampled at grant
led_done  out  1  1-cycle pulse; LED transaction ACKed
led_err  out  1  1-cycle pulse; LED transaction aborted
cmd_req  in  1  level; request generic command
cmd_byte  in  8  first byte; sampled at grant
cmd_has_arg  in  1  1 = also send cmd_arg
cmd_arg  in  8  second byte; sampled at grant
cmd_done  out  1  1-cycle pulse; command ACKed
cmd_err  out  1  1-cycle pulse; command aborted
busy  out  1  transaction in progress
the_command  out  8  to Ps2Controller
send_command  out  1  to Ps2Controller
command_was_sent  in  1  from Ps2Controller
error_communication_timed_out  in  1  from Ps2Controller
received_data  in  8  from Ps2Controller
received_data_en  in  1  from Ps2Controller; 1-cycle strobe
scan_data  out  8  forwarded byte
scan_valid  out  1  1-cycle strobe; latency 1 from received_data_en

Behaviour:
- Reset (async, reset_n=0): every output is 0; state IDLE; last_grant=cmd, so LED is favoured first; retry count 0; timer 0.
- Arbitration in IDLE:
  - If exactly one request is high, grant it.
  - If both are high, grant the one not granted last (round-robin).
  - At the grant cycle, latch the byte list:
    - LED: {8'hED, {5'b0,led_state}}.
    - CMD: {cmd_byte, cmd_arg}, length 1 + cmd_has_arg.
  - Next state is SEND; busy=1 from the next cycle.
  - Requests dropped after grant have no effect. The transaction completes.
- SEND:
  - send_command=1, the_command=current byte, both registered.
  - command_was_sent=1 → send_command=0 next cycle; clear timer; go to WAIT_ACK.
  - error_communication_timed_out=1 → send_command=0; go to RETRY.
  - If both assert in the same cycle, command_was_sent wins.
- WAIT_ACK:
  - Timer increments each cycle.
  - received_data_en with 0xFA:
    - More bytes remain → next byte; retry count=0; SEND.
    - Otherwise → DONE.
  - received_data_en with 0xFE → RETRY.
  - Any other byte is forwarded to scan_data and the block keeps waiting.
  - Timer reaching ACK_TIMEOUT_CYCLES-1 → RETRY.
  - ACK in the same cycle as timer expiry: ACK wins.
- RETRY:
  - Spend one cycle with send_command=0 so Ps2Controller can return to idle.
  - retry count < MAX_RETRY → increment; SEND the same byte.
  - Else → ERR.
- DONE: owner's *_done=1 for one cycle; update last_grant; go to IDLE; busy=0 the next cycle.
- ERR: owner's *_err=1 for one cycle; remaining bytes are discarded; update last_grant; go to IDLE.
- Scan forwarding:
  - In all states other than WAIT_ACK, every received_data_en byte goes to scan_data/scan_valid, one cycle later.
  - In WAIT_ACK, 0xFA and 0xFE are consumed and never forwarded.
- send_command is never high for two consecutive transactions without at least one low cycle between them.
- Minimum idle-to-SEND latency: 1 cycle after grant.
- A mid-operation reset drops send_command asynchronously. No done/err pulse is issued.

Decomposition:
- Package ps2_seq_pkg holds:
  - the state enum: IDLE, SEND, WAIT_ACK, RETRY, DONE, ERR;
  - constants PS2_ACK=8'hFA, PS2_RESEND=8'hFE, PS2_CMD_SET_LEDS=8'hED;
  - owner encoding OWN_LED=0, OWN_CMD=1.
- Sub-module ps2_req_arbiter: 2-way round-robin arbiter with last_grant register; grant qualified by IDLE.

Test Plan:
- LED request, led_state=3'b101; model ACKs each byte → the_command=0xED then 0x05; led_done pulse once; no scan_valid for either 0xFA.
- cmd_req with cmd_byte=0xF4, cmd_has_arg=0 → one SEND; ACK → cmd_done; busy low 1 cycle after the done pulse.
- led_req and cmd_req both asserted from reset and held → grant order LED, CMD, LED, CMD (round-robin).
- Model replies 0xFE to byte 0xED three times, then 0xFA → 0xED sent 4 times; byte 2 then sent; led_done.
- Model never ACKs, with ACK_TIMEOUT_CYCLES=100 → 4 attempts at ~100-cycle spacing; then cmd_err pulse; 2nd byte never sent.
- Scan byte 0x1C arrives during WAIT_ACK, followed by 0xFA → scan_data=0x1C with scan_valid 1 cycle later; transaction completes. Reset asserted mid-SEND → send_command=0 immediately; no done/err pulse.
